x_mem_responder: RTL
====================

X_MEM_RESPONDER -- requirements
Module: x_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per request (0..15).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  initiator request valid; held until accepted.
REQ-006 SHALL have port i_rnw  input  1  1 = read, 0 = write.
REQ-007 SHALL have port i_addr  input  32  byte address.
REQ-008 SHALL have port i_data  input  32  write data.
REQ-009 SHALL have port o_accept  output  1  one-cycle completion strobe.
REQ-010 SHALL have port o_data  output  32  read data, valid in the o_accept cycle.
REQ-011 SHALL have port o_gpio  output  32  memory-mapped output register.
REQ-012 SHALL have port o_err  output  1  sticky out-of-range access flag.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE with i_valid=1, SHALL capture i_rnw, i_addr and i_data into request registers; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 On entry to WAIT, SHALL load a 4-bit counter with WAIT_CYCLES-1, decrement it each cycle, and go to RESP in the cycle after it reads 0.
REQ-016 In RESP, SHALL drive o_accept=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency from the first i_valid cycle (in IDLE) to the o_accept cycle SHALL be 1+WAIT_CYCLES clocks; back-to-back requests SHALL complete every 2+WAIT_CYCLES clocks.
REQ-018 Inputs sampled outside IDLE SHALL be ignored; a request is committed only from the captured copy.
REQ-019 Word index SHALL be addr[2+:log2(DEPTH_WORDS)]; addr[1:0] SHALL be ignored (word accesses only).
REQ-020 An access SHALL be in-range when addr < DEPTH_WORDS*4.
REQ-021 An in-range read SHALL return the RAM word on o_data in the RESP cycle; the RAM read SHALL be issued one cycle earlier (synchronous read).
REQ-022 An in-range write SHALL update the RAM in the RESP cycle; a read of the same word in the next request SHALL return the new value.
REQ-023 An out-of-range read SHALL return 32'h0; an out-of-range write SHALL be dropped; both SHALL still be accepted and SHALL set o_err.
REQ-024 o_data SHALL be 32'h0 in every cycle other than an accepted read.
REQ-025 o_err SHALL remain 1 until reset.

Reset
REQ-026 On i_rst=1, SHALL immediately force the FSM to IDLE, counter to 0, o_accept=0, o_data=0, o_gpio=0, o_err=0.
REQ-027 Reset asserted during WAIT or RESP SHALL abort the request with no RAM or GPIO write and no accept.
REQ-028 RAM contents SHALL NOT be reset (undefined until written).

Configuration
REQ-029 With macro X_MEM_RESPONDER_GPIO_EN defined, address 32'h8000_0000 SHALL map to the o_gpio register: a write updates it in the RESP cycle, a read returns its value, and o_err is not set.
REQ-030 Without X_MEM_RESPONDER_GPIO_EN, o_gpio SHALL be tied to 0 and 32'h8000_0000 SHALL behave as out-of-range.

Structure
REQ-031 Package x_mem_pkg SHALL hold the FSM state enum, the GPIO_ADDR constant (32'h8000_0000), and the out-of-range read value constant.
REQ-032 The RAM SHALL be the sub-module x_mem_ram: single-port, synchronous read, write enable, DEPTH_WORDS parameter.

Verification
REQ-033 WAIT_CYCLES=0: write 0x1234_5678 to 0x10, then read 0x10 -> each o_accept arrives 1 cycle after i_valid, and the read returns 0x1234_5678.
REQ-034 WAIT_CYCLES=3: read 0x4 after writing 0xA5A5_A5A5 -> o_accept arrives exactly 4 cycles after i_valid, o_data=0xA5A5_A5A5, and o_accept is high for 1 cycle only.
REQ-035 DEPTH_WORDS=1024: read 0x1000 -> accepted, o_data=0, o_err=1; o_err stays 1 after later in-range accesses.
REQ-036 GPIO_EN defined: write 0xCAFE_0001 to 0x8000_0000 -> o_gpio=0xCAFE_0001 from the cycle after accept, read-back returns the same, o_err=0; undefined: o_gpio stays 0 and o_err=1.
REQ-037 Assert i_rst in WAIT during a write of 0xFFFF_FFFF to 0x20 -> no o_accept, then after reset a read of 0x20 returns the prior value.
REQ-038 Back-to-back requests with i_valid held high (initiator fetch after load) -> two distinct accepts 2+WAIT_CYCLES cycles apart, each with the correct address captured.

Source files
------------

// File: rtl/x_mem_pkg.sv
// Shared types and constants for the x_mem_responder memory target:
// FSM state encoding, the GPIO register address and the out-of-range read value.
package x_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Plain vector copies of the state encoding for use with logic-typed state registers.
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_WAIT = S_WAIT;
  localparam logic [1:0] ST_RESP = S_RESP;

  localparam logic [31:0] GPIO_ADDR = 32'h8000_0000;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  function automatic logic is_gpio_addr(input logic [31:0] addr);
    return addr == GPIO_ADDR;
  endfunction

endpackage

// File: rtl/x_mem_ram.sv
// Single-port word RAM with synchronous read and write enable.
// Contents are never reset; a write cycle leaves the read register unchanged.
module x_mem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/x_mem_responder.sv
// Memory-mapped word responder: RAM with configurable wait states, a sticky error flag
// and an optional GPIO output register enabled by X_MEM_RESPONDER_GPIO_EN.
module x_mem_responder
  import x_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio,
  output logic        o_err,
  output logic [1:0]  dbg_state
);

  // Handshake: the initiator holds i_valid (with i_rnw/i_addr/i_data stable) until
  // o_accept; the request is sampled only in IDLE, and o_accept pulses for one cycle
  // (RESP) carrying read data on o_data. Inputs seen in WAIT or RESP are ignored.

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic          req_rnw;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          take;
  logic          resp;
  logic          in_range;
  logic          gpio_hit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic [31:0]   gpio_q;
  logic [31:0]   rd_mux;
  logic          err_q;

  assign take = (state == ST_IDLE) && i_valid;
  assign resp = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_valid) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      req_rnw  <= 1'b0;
      req_addr <= 32'h0;
      req_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cnt      <= WAIT_LOAD;
        req_rnw  <= i_rnw;
        req_addr <= i_addr;
        req_data <= i_data;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // The RAM is read every cycle so the word is registered on the edge entering RESP;
  // with no wait states that read must come straight from the live address in IDLE.
  assign in_range = (req_addr < BYTE_LIMIT);
  assign ram_addr = (state == ST_IDLE) ? i_addr[2 +: AW] : req_addr[2 +: AW];
  assign ram_we   = resp && !req_rnw && in_range;

  x_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

`ifdef X_MEM_RESPONDER_GPIO_EN
  assign gpio_hit = is_gpio_addr(req_addr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gpio_q <= 32'h0;
    end else if (resp && gpio_hit && !req_rnw) begin
      gpio_q <= req_data;
    end
  end
`else
  assign gpio_hit = 1'b0;
  assign gpio_q   = 32'h0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (resp && !in_range && !gpio_hit) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = OOR_RDATA;
    if (in_range) begin
      rd_mux = ram_rdata;
    end else if (gpio_hit) begin
      rd_mux = gpio_q;
    end
  end

  assign o_accept  = resp;
  assign o_data    = (resp && req_rnw) ? rd_mux : 32'h0;
  assign o_gpio    = gpio_q;
  assign o_err     = err_q;
  assign dbg_state = state;

endmodule
